// File: rtl/bayer_pkg.sv
// Shared Bayer demosaic types: sensor pattern, sample colour and the per-site colour lookup.
package bayer_pkg;

  typedef enum logic [1:0] {RGGB, GRBG, GBRG, BGGR} bayer_pattern_t;
  typedef enum logic [1:0] {RED, GREEN, BLUE} bayer_colour_t;

  // Pattern names read row-major over the 2x2 tile starting at (even,even).
  function automatic bayer_colour_t colour_at(bayer_pattern_t pattern, logic x_odd, logic y_odd);
    bayer_colour_t c;
    case (pattern)
      RGGB:    c = (x_odd ^ y_odd) ? GREEN : (x_odd ? BLUE : RED);
      BGGR:    c = (x_odd ^ y_odd) ? GREEN : (x_odd ? RED : BLUE);
      GRBG:    c = (x_odd ^ y_odd) ? (x_odd ? RED : BLUE) : GREEN;
      GBRG:    c = (x_odd ^ y_odd) ? (x_odd ? BLUE : RED) : GREEN;
      default: c = GREEN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/raw_line_buffer.sv
// One line of raw samples; simple dual-port RAM with registered read (old data on same-address write).
// Latency 1 cycle on read, no backpressure.
module raw_line_buffer #(
  parameter int WIDTH = 640,
  parameter int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk_pixel,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [WIDTH];

  always_ff @(posedge clk_pixel) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bayer_demosaic.sv
// Raw Bayer stream to 24-bit RGB via 2x2 nearest-neighbour window; fixed 2-cycle latency.
// No backpressure: one rgb_valid per accepted pixel, gaps pass through unchanged.
module bayer_demosaic
  import bayer_pkg::*;
#(
  parameter int             WIDTH   = 640,
  parameter int             HEIGHT  = 480,
  parameter bayer_pattern_t PATTERN = BGGR
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel,
  output logic        rgb_valid,
  output logic [23:0] rgb
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] column, x_cur, x_next;
  logic [RW-1:0] row, y_cur, y_next;
  logic [7:0]    rd_data;

  logic       s1_vld, s1_x_odd, s1_y_odd, s1_border;
  logic [7:0] s1_d, win_a, win_c;

  logic [7:0] r_sel, b_sel;
  logic [8:0] g_sum;
  logic [7:0] win [4];
  logic [3:0] xo, yo;

  // frame_start relabels the pixel accepted in the same cycle as (0,0).
  always_comb begin
    x_cur = frame_start ? '0 : column;
    y_cur = frame_start ? '0 : row;
    if (x_cur == CW'(WIDTH - 1)) begin
      x_next = '0;
      y_next = (y_cur == RW'(HEIGHT - 1)) ? '0 : y_cur + 1'b1;
    end else begin
      x_next = x_cur + 1'b1;
      y_next = y_cur;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      column <= '0;
      row    <= '0;
    end else if (pixel_valid) begin
      column <= x_next;
      row    <= y_next;
    end else if (frame_start) begin
      column <= '0;
      row    <= '0;
    end
  end

  raw_line_buffer #(.WIDTH(WIDTH), .AW(CW)) u_line (
    .clk_pixel (clk_pixel),
    .wr_en     (pixel_valid),
    .wr_addr   (x_cur),
    .wr_data   (pixel),
    .rd_addr   (x_cur),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_d      <= '0;
      s1_x_odd  <= 1'b0;
      s1_y_odd  <= 1'b0;
      s1_border <= 1'b0;
      win_a     <= '0;
      win_c     <= '0;
    end else begin
      s1_vld <= pixel_valid;
      if (pixel_valid) begin
        s1_d      <= pixel;
        s1_x_odd  <= x_cur[0];
        s1_y_odd  <= y_cur[0];
        s1_border <= (x_cur == '0) || (y_cur == '0);
      end
      // Current B/D become the next pixel's A/C.
      if (s1_vld) begin
        win_a <= rd_data;
        win_c <= s1_d;
      end
    end
  end

  // Window order A,B,C,D; parity of each position relative to D.
  always_comb begin
    win   = '{win_a, rd_data, win_c, s1_d};
    xo    = {s1_x_odd, ~s1_x_odd, s1_x_odd, ~s1_x_odd};
    yo    = {s1_y_odd, s1_y_odd, ~s1_y_odd, ~s1_y_odd};
    r_sel = '0;
    b_sel = '0;
    g_sum = '0;
    for (int i = 0; i < 4; i++) begin
      case (colour_at(PATTERN, xo[i], yo[i]))
        RED:     r_sel = win[i];
        BLUE:    b_sel = win[i];
        default: g_sum = g_sum + 9'(win[i]);
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      rgb_valid <= 1'b0;
      rgb       <= '0;
    end else begin
      rgb_valid <= s1_vld;
      if (s1_vld) rgb <= s1_border ? 24'h000000 : {r_sel, g_sum[8:1], b_sel};
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Directed bench: BGGR and RGGB instances share one 4x4 input stream, outputs checked per cycle.
module tb_bayer_demosaic;
  import bayer_pkg::*;

  logic        clk_pixel   = 1'b0;
  logic        reset       = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel       = 8'd0;
  logic        b_vld, r_vld;
  logic [23:0] b_rgb, r_rgb;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int vld_at = -1;

  logic        pend_vld = 1'b0;
  logic [23:0] pend_b = '0, pend_r = '0, last_b = '0, last_r = '0;

  always #5 clk_pixel = ~clk_pixel;

  bayer_demosaic #(.WIDTH(4), .HEIGHT(4), .PATTERN(BGGR)) u_bggr (
    .clk_pixel (clk_pixel), .reset (reset), .frame_start (frame_start),
    .pixel_valid (pixel_valid), .pixel (pixel), .rgb_valid (b_vld), .rgb (b_rgb)
  );

  bayer_demosaic #(.WIDTH(4), .HEIGHT(4), .PATTERN(RGGB)) u_rggb (
    .clk_pixel (clk_pixel), .reset (reset), .frame_start (frame_start),
    .pixel_valid (pixel_valid), .pixel (pixel), .rgb_valid (r_vld), .rgb (r_rgb)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; outputs seen after this edge belong to the previous call's input.
  task automatic tick(input logic v, input logic [7:0] p, input logic fs,
                      input logic [23:0] eb, input logic [23:0] er, input string tag);
    pixel_valid = v;
    pixel       = p;
    frame_start = fs;
    @(posedge clk_pixel);
    #1;
    chk({tag, "/vld_bggr"}, 24'(b_vld), 24'(pend_vld));
    chk({tag, "/vld_rggb"}, 24'(r_vld), 24'(pend_vld));
    if (pend_vld) begin
      last_b = pend_b;
      last_r = pend_r;
    end
    chk({tag, "/rgb_bggr"}, b_rgb, last_b);
    chk({tag, "/rgb_rggb"}, r_rgb, last_r);
    if (b_vld) n_out++;
    pend_vld = v;
    pend_b   = eb;
    pend_r   = er;
  endtask

  // s1: BGGR R=200 G=100 B=50; s2: as s1 but G at (even,odd)=51; s3: s1 relabelled for RGGB.
  function automatic logic [7:0] pix(input int s, input int x, input int y);
    if ((x % 2) == 1 && (y % 2) == 1) return (s == 3) ? 8'd50 : 8'd200;
    if ((x % 2) == 0 && (y % 2) == 0) return (s == 3) ? 8'd200 : 8'd50;
    if ((x % 2) == 1) return 8'd100;
    return (s == 2) ? 8'd51 : 8'd100;
  endfunction

  function automatic logic [23:0] exp_bggr(input int s);
    case (s)
      1:       return 24'hC86432;
      2:       return 24'hC84B32;
      default: return 24'h3264C8;
    endcase
  endfunction

  function automatic logic [23:0] exp_rggb(input int s);
    case (s)
      1:       return 24'h3264C8;
      2:       return 24'h324BC8;
      default: return 24'hC86432;
    endcase
  endfunction

  task automatic send_px(input int s, input int x, input int y, input logic fs, input int gap);
    logic border;
    border = (x == 0) || (y == 0);
    tick(1'b1, pix(s, x, y), fs, border ? 24'h0 : exp_bggr(s), border ? 24'h0 : exp_rggb(s),
         $sformatf("s%0d(%0d,%0d)", s, x, y));
    repeat (gap) tick(1'b0, 8'd0, 1'b0, 24'h0, 24'h0, "gap");
  endtask

  task automatic send_frame(input int s, input logic fs, input int gap);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        send_px(s, x, y, fs && (x == 0) && (y == 0), gap);
    tick(1'b0, 8'd0, 1'b0, 24'h0, 24'h0, "flush");
  endtask

  initial begin
    #2;
    chk("reset/vld_bggr", 24'(b_vld), 24'h0);
    chk("reset/rgb_bggr", b_rgb, 24'h0);
    chk("reset/vld_rggb", 24'(r_vld), 24'h0);
    chk("reset/rgb_rggb", r_rgb, 24'h0);
    repeat (2) @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    tick(1'b0, 8'd0, 1'b0, 24'h0, 24'h0, "idle");

    send_frame(1, 1'b1, 0);
    send_frame(2, 1'b1, 0);
    send_frame(3, 1'b1, 0);

    // Lone pixel at (0,0): output exactly one edge after capture.
    for (int i = 0; i < 15; i++) begin
      tick(i == 10, 8'd77, 1'b0, 24'h0, 24'h0, "lone");
      if (b_vld && vld_at < 0) vld_at = i;
    end
    chk("lone/latency", 24'(vld_at), 24'd11);

    n_out = 0;
    send_frame(1, 1'b1, 3);
    chk("gap/out_count", 24'(n_out), 24'd16);

    // Restart mid-frame at (2,1); new frame must not see old rows.
    for (int k = 0; k < 6; k++) send_px(1, k % 4, k / 4, k == 0, 0);
    send_frame(2, 1'b1, 0);

    // Reset arriving where (3,2) would be accepted.
    for (int k = 0; k < 11; k++) send_px(3, k % 4, k / 4, k == 0, 0);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    reset       = 1'b1;
    #1;
    chk("arst/vld_bggr", 24'(b_vld), 24'h0);
    chk("arst/rgb_bggr", b_rgb, 24'h0);
    chk("arst/vld_rggb", 24'(r_vld), 24'h0);
    chk("arst/rgb_rggb", r_rgb, 24'h0);
    @(posedge clk_pixel);
    #1;
    chk("arst_hold/vld_bggr", 24'(b_vld), 24'h0);
    chk("arst_hold/rgb_bggr", b_rgb, 24'h0);
    reset    = 1'b0;
    pend_vld = 1'b0;
    last_b   = '0;
    last_r   = '0;
    send_frame(1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
